// File: rtl/mux_vec_pkg.sv
// Shared value encoding, FSM states and sweep length for the mux vector generator.
// Build option MUX_VEC_X_INPUTS_EN adds x as a third input value (27 vectors per pass instead of 8).
package mux_vec_pkg;

    localparam logic [1:0] V0 = 2'b00;
    localparam logic [1:0] V1 = 2'b01;
    localparam logic [1:0] VX = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

`ifdef MUX_VEC_X_INPUTS_EN
    localparam int RADIX = 3;
`else
    localparam int RADIX = 2;
`endif

    localparam int         LAST      = RADIX * RADIX * RADIX - 1;
    localparam logic [1:0] DIGIT_MAX = 2'(RADIX - 1);

endpackage

// File: rtl/mux_udp_model.sv
// Golden combinational model of the 2:1 select mux over 3-valued (0/1/x) encoded inputs.
// Any non-binary input value, including the unused 2'b11 code, is treated as x.
module mux_udp_model
    import mux_vec_pkg::*;
(
    input  logic [1:0] s_i,
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [1:0] q_o
);

    logic aKnown;
    logic bKnown;

    assign aKnown = (a_i == V0) || (a_i == V1);
    assign bKnown = (b_i == V0) || (b_i == V1);

    // An unknown select only resolves when both data inputs agree on a known value.
    always_comb begin
        q_o = VX;
        case (s_i)
            V0:      q_o = aKnown ? a_i : VX;
            V1:      q_o = bKnown ? b_i : VX;
            default: q_o = (aKnown && (a_i == b_i)) ? a_i : VX;
        endcase
    end

endmodule

// File: rtl/mux_vector_gen.sv
// Sweeps every (S, A, B) combination NUM_PASSES times over a valid/ready handshake with golden Q.
// Build option MUX_VEC_X_INPUTS_EN includes x in the sweep; otherwise only 0/1 are generated.
module mux_vector_gen
    import mux_vec_pkg::*;
#(
    parameter int NUM_PASSES = 1,
    parameter int IDX_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_s,
    output logic [1:0]       out_a,
    output logic [1:0]       out_b,
    output logic [1:0]       out_q,
    output logic [IDX_W-1:0] vec_idx,
    output logic [7:0]       pass_cnt
);

    state_e           state_q,   state_d;
    logic [IDX_W-1:0] vecIdx_q,  vecIdx_d;
    logic [7:0]       passCnt_q, passCnt_d;
    logic [1:0]       sDig_q,    sDig_d;
    logic [1:0]       aDig_q,    aDig_d;
    logic [1:0]       bDig_q,    bDig_d;
    logic             transfer;
    logic             lastVec;
    logic             lastPass;

    assign transfer = (state_q == RUN) && out_ready;
    assign lastVec  = (vecIdx_q == IDX_W'(LAST));
    assign lastPass = (passCnt_q == 8'(NUM_PASSES - 1));

    // The S/A/B digits are kept as an odometer alongside vec_idx so no divider is needed.
    always_comb begin
        state_d   = state_q;
        vecIdx_d  = vecIdx_q;
        passCnt_d = passCnt_q;
        sDig_d    = sDig_q;
        aDig_d    = aDig_q;
        bDig_d    = bDig_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    vecIdx_d  = '0;
                    passCnt_d = '0;
                    sDig_d    = V0;
                    aDig_d    = V0;
                    bDig_d    = V0;
                end
            end
            RUN: begin
                if (transfer) begin
                    if (lastVec) begin
                        vecIdx_d = '0;
                        sDig_d   = V0;
                        aDig_d   = V0;
                        bDig_d   = V0;
                        if (lastPass) begin
                            state_d = DONE;
                        end else begin
                            passCnt_d = passCnt_q + 8'd1;
                        end
                    end else begin
                        vecIdx_d = vecIdx_q + 1'b1;
                        if (bDig_q != DIGIT_MAX) begin
                            bDig_d = bDig_q + 2'd1;
                        end else begin
                            bDig_d = V0;
                            if (aDig_q != DIGIT_MAX) begin
                                aDig_d = aDig_q + 2'd1;
                            end else begin
                                aDig_d = V0;
                                sDig_d = sDig_q + 2'd1;
                            end
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            vecIdx_q  <= '0;
            passCnt_q <= '0;
            sDig_q    <= V0;
            aDig_q    <= V0;
            bDig_q    <= V0;
        end else begin
            state_q   <= state_d;
            vecIdx_q  <= vecIdx_d;
            passCnt_q <= passCnt_d;
            sDig_q    <= sDig_d;
            aDig_q    <= aDig_d;
            bDig_q    <= bDig_d;
        end
    end

    mux_udp_model u_model (
        .s_i (sDig_q),
        .a_i (aDig_q),
        .b_i (bDig_q),
        .q_o (out_q)
    );

    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign out_s     = sDig_q;
    assign out_a     = aDig_q;
    assign out_b     = bDig_q;
    assign vec_idx   = vecIdx_q;
    assign pass_cnt  = passCnt_q;

endmodule
